// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response channels, redirect input,
// decode-side instruction channel and performance counter outputs.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic [4:0]      opcode_eff;
    logic [2:0]      funct3;
    logic            funct7_fif;
    logic [31:0]     perf_fetch;
    logic [31:0]     perf_stall;
    logic [31:0]     perf_flush;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc, inst_ready,
        output inst_valid, inst, inst_pc, opcode_eff, funct3, funct7_fif,
        output perf_fetch, perf_stall, perf_flush
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc, inst_ready,
        input  inst_valid, inst, inst_pc, opcode_eff, funct3, funct7_fif,
        input  perf_fetch, perf_stall, perf_flush
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: credit-limited imem requests, in-order response queue, redirect flush.
// Optional free-running perf counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    localparam int          CW = $clog2(QDEPTH) + 1;
    localparam int          PW = $clog2(QDEPTH);
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [XLEN-1:0] pc, rsp_pc, target;
    logic [31:0]     q_inst [QDEPTH];
    logic [XLEN-1:0] q_pc   [QDEPTH];
    ptr_t            rd_ptr, wr_ptr;
    cnt_t            q_count, outstanding, drop;
    logic            head_valid, pop, push, rsp_take, req_fire;
    logic [CW:0]     credit;
    logic            unused_redirect_lsbs;

    assign target               = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign head_valid = (q_count != '0);
    assign pop        = head_valid && bus.inst_ready && !bus.redirect;
    // Responses with nothing outstanding belong to requests issued before reset.
    assign rsp_take   = bus.imem_rsp_valid && (outstanding != '0);
    assign push       = rsp_take && (drop == '0) && !bus.redirect;

    // A same-cycle dequeue frees its slot, sustaining one fetch per cycle.
    assign credit = {1'b0, q_count} + {1'b0, outstanding} - {1'b0, drop}
                  - {{CW{1'b0}}, pop};

    assign bus.imem_req_valid = !rst && !bus.redirect && (credit < QD);
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q_count     <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_take);
            if (bus.redirect) begin
                pc      <= target;
                rsp_pc  <= target;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                q_count <= '0;
                drop    <= outstanding - cnt_t'(rsp_take);
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= wr_ptr + ptr_t'(1);
                end
                if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
                q_count <= q_count + cnt_t'(push) - cnt_t'(pop);
                if (rsp_take && (drop != '0)) drop <= drop - cnt_t'(1);
            end
        end
    end

    // NOTE: queue storage carries no reset; q_count gates every read of it,
    // so stale contents are never visible and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= bus.imem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end

    // NOTE: every output is defaulted before the conditional to avoid latches.
    always_comb begin
        bus.inst_valid = head_valid;
        bus.inst       = '0;
        bus.inst_pc    = '0;
        if (head_valid) begin
            bus.inst    = q_inst[rd_ptr];
            bus.inst_pc = q_pc[rd_ptr];
        end
    end

    assign bus.opcode_eff = bus.inst[6:2];
    assign bus.funct3     = bus.inst[14:12];
    assign bus.funct7_fif = bus.inst[30];

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push)         fetch_cnt <= fetch_cnt + 32'd1;
            if (!head_valid)  stall_cnt <= stall_cnt + 32'd1;
            if (bus.redirect) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.perf_fetch = fetch_cnt;
    assign bus.perf_stall = stall_cnt;
    assign bus.perf_flush = flush_cnt;
`else
    assign bus.perf_fetch = '0;
    assign bus.perf_stall = '0;
    assign bus.perf_flush = '0;
`endif
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RV32I core, directly upstream of `control_unit`. It holds the PC and issues in-order requests to instruction memory over a valid/ready request channel. Responses are buffered in a small queue, and each queued instruction is presented to decode with its PC and the pre-sliced control-unit fields (`opcode_eff`, `funct3`, `funct7_fif`). The downstream redirect (PCSel taken, target from ALU) flushes the queue and discards in-flight responses.

## Interface
- `XLEN`, 32, PC/address width
- `RESET_PC`, 32'h0000_0000, PC loaded at reset
- `QDEPTH`, 2, instruction queue depth; power of 2, ≥2

- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `imem_req_valid` out 1, fetch request valid
- `imem_req_ready` in 1, memory accepts request
- `imem_req_addr` out XLEN, word-aligned fetch address
- `imem_rsp_valid` in 1, response valid; in order, ≥1 cycle after accept, never back-pressured
- `imem_rsp_data` in 32, instruction word
- `redirect` in 1, taken control transfer (PCSel=1 from control_unit)
- `redirect_pc` in XLEN, target PC (ALU result)
- `inst_valid` out 1, queue head valid
- `inst_ready` in 1, decode consumes head
- `inst` out 32, head instruction
- `inst_pc` out XLEN, PC of head instruction
- `opcode_eff` out 5, `inst[6:2]`
- `funct3` out 3, `inst[14:12]`
- `funct7_fif` out 1, `inst[30]`
- `perf_fetch` out 32, accepted non-dropped responses
- `perf_stall` out 32, cycles with `inst_valid`=0 outside reset
- `perf_flush` out 32, redirect count

## Operation
- Registers: `pc` (next fetch address), `rsp_pc` (PC of next useful response), queue (`QDEPTH` entries of inst+pc), `outstanding` count, `drop` count. Both counters are `$clog2(QDEPTH)+1` bits.
- Reset values: `pc`=`rsp_pc`=`RESET_PC`, queue empty, `outstanding`=`drop`=0. All outputs are 0 except `imem_req_addr`=`RESET_PC`. Perf counters are 0.
- Request issue:
  - `imem_req_valid` = !`redirect` && (queue count + `outstanding` − `drop` < `QDEPTH`).
  - `imem_req_addr`=`pc`.
  - On handshake: `pc`+=4 (wraps modulo 2^XLEN) and `outstanding`++.
- Response handling: every `imem_rsp_valid` decrements `outstanding`.
  - If `drop`>0, or `redirect` is high the same cycle: discard the response and decrement `drop` if it is nonzero.
  - Otherwise: push {data, `rsp_pc`} to the queue and add 4 to `rsp_pc`.
- Credit rule guarantees a push never hits a full queue. An overflow attempt is a design error; the bench flags it.
- Dequeue: on `inst_valid` && `inst_ready`.
- Redirect has priority over all other events in the same cycle:
  - Queue cleared; a simultaneous dequeue is ignored.
  - `pc`=`rsp_pc`={`redirect_pc`[XLEN-1:2],2'b00}.
  - `drop` set to `outstanding` after this cycle's response decrement.
  - No request is issued that cycle.
- Consecutive redirects: the latest target wins, and `drop` is recomputed each time.
- `opcode_eff`, `funct3` and `funct7_fif` are combinational slices of `inst`. They are 0 when the queue is empty.

## Timing
- Request accepted at edge N, response at N+k (k≥1). The response is pushed at that response's edge, and `inst_valid` is high the following cycle. Minimum fetch-to-decode latency is 2 cycles.
- Throughput: one instruction per cycle at k=1 with `QDEPTH`≥2 and `inst_ready` held high.
- Redirect asserted in cycle R: `inst_valid`=0 in R+1. The first request to the target is in R+1. The first target instruction can be valid at R+3 (k=1).
- Empty-queue bypass: none. Data always passes through a queue register.
- `rst` asserted mid-operation: all state clears asynchronously. Responses arriving after deassert for pre-reset requests are ignored, because `outstanding`=0 means any `imem_rsp_valid` is discarded.

## Configuration
- `IFU_PERF_CNT_EN`: when defined, `perf_fetch`, `perf_stall` and `perf_flush` are free-running 32-bit wrapping counters. When undefined, the counter logic is omitted and the three ports are tied to 0.

## Test plan
- Reset with `RESET_PC`=0x100 and an ideal memory (ready=1, k=1) holding `addi`/`add`/`sw` -> first `imem_req_addr`=0x100. `inst_pc` sequence is 0x100, 0x104, 0x108; `opcode_eff` sequence is 5'b00100, 5'b01100, 5'b01000.
- `inst_ready`=0 for 10 cycles -> at most `QDEPTH` requests are outstanding plus queued, `imem_req_valid` drops, and no instruction is lost when ready returns.
- Memory with k=3 and two requests in flight, then `redirect`=1 with `redirect_pc`=0x203 -> both stale responses are dropped, the next request address is 0x200, and the first `inst_pc` after the redirect is 0x200.
- `redirect` coincident with `imem_rsp_valid` and `inst_ready` -> that response is discarded, the dequeue is ignored, and `inst_valid`=0 next cycle.
- `rst` pulsed while 2 requests are outstanding -> outputs are at reset values immediately, late responses are ignored, and fetch restarts at `RESET_PC`.
- With `IFU_PERF_CNT_EN`: one redirect plus 8 delivered instructions -> `perf_flush`=1 and `perf_fetch`=8. Without the macro, all perf outputs are 0.
